// File: rtl/jpeg_tpose_pp.sv
// jpeg_tpose_pp: row-in / vector-out block buffer for 2-D transforms.
//
// Rows of N W-bit elements are written into an N x N bank. Once a bank holds
// N rows, it is read out as N vectors. A block is either transposed (column
// per vector) or passed straight through (row per vector). The choice is
// latched per bank from mode_i on the block's first row. With DBUF=1, two
// banks ping-pong, so writing one block and reading another can overlap at
// full rate.
//
// Ports
//   clk_i       sole clock, rising edge
//   rst_i       asynchronous active-low reset
//   wr_i        write one row (accepted when wr_ready_o=1)
//   in_i        row data, element k at [k*W +: W]
//   mode_i      1 = transpose, 0 = pass-through; sampled on row 0
//   wr_ready_o  current write bank is not full
//   rd_i        consume one output vector (accepted when rd_valid_o=1)
//   ut_o        output vector, element r at [r*W +: W]
//   rd_valid_o  current read bank is full
//   flush_i     synchronous clear of pointers, full flags and ovf_o
//   ovf_o       sticky: a write was attempted while wr_ready_o=0
module jpeg_tpose_pp #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 12,
  parameter int unsigned DBUF = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_i,
  input  logic [N*W-1:0] in_i,
  input  logic           mode_i,
  output logic           wr_ready_o,
  input  logic           rd_i,
  output logic [N*W-1:0] ut_o,
  output logic           rd_valid_o,
  input  logic           flush_i,
  output logic           ovf_o
);

  localparam int unsigned NB   = (DBUF != 0) ? 2 : 1;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] Last = CW'(N - 1);

  logic [W-1:0]  mem_q [NB][N][N];
  logic [NB-1:0] full_q, full_d;
  logic [NB-1:0] mode_q, mode_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          ovf_q, ovf_d;
  logic          wr_acc, rd_acc;

  assign wr_ready_o = ~full_q[wbank_q];
  assign rd_valid_o = full_q[rbank_q];
  assign ovf_o      = ovf_q;

  // Flush wins over any simultaneous transfer.
  assign wr_acc = wr_i & wr_ready_o & ~flush_i;
  assign rd_acc = rd_i & rd_valid_o & ~flush_i;

  always_comb begin
    full_d  = full_q;
    mode_d  = mode_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ovf_d   = ovf_q;

    if (flush_i) begin
      full_d  = '0;
      wbank_d = 1'b0;
      rbank_d = 1'b0;
      wcnt_d  = '0;
      rcnt_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_i && !wr_ready_o) begin
        ovf_d = 1'b1;
      end

      // A completing read and a completing write never target the same bank:
      // the write needs its bank empty, the read needs its bank full.
      if (rd_acc) begin
        if (rcnt_q == Last) begin
          full_d[rbank_q] = 1'b0;
          rcnt_d          = '0;
          rbank_d         = (NB == 2) ? ~rbank_q : 1'b0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      if (wr_acc) begin
        if (wcnt_q == '0) begin
          mode_d[wbank_q] = mode_i;
        end
        if (wcnt_q == Last) begin
          full_d[wbank_q] = 1'b1;
          wcnt_d          = '0;
          wbank_d         = (NB == 2) ? ~wbank_q : 1'b0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q  <= '0;
      mode_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      mode_q  <= mode_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array carries no reset; validity is tracked by full_q alone.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int k = 0; k < N; k++) begin
        mem_q[wbank_q][wcnt_q][CW'(k)] <= in_i[k*W +: W];
      end
    end
  end

  // Transpose reads column rcnt; pass-through reads row rcnt.
  always_comb begin
    ut_o = '0;
    for (int r = 0; r < N; r++) begin
      if (mode_q[rbank_q]) begin
        ut_o[r*W +: W] = mem_q[rbank_q][CW'(r)][rcnt_q];
      end else begin
        ut_o[r*W +: W] = mem_q[rbank_q][rcnt_q][CW'(r)];
      end
    end
  end

endmodule
